// File: rtl/nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_if
//   Handshake bundle for nibble_serial_adder: an operand stream carrying one
//   nibble pair per beat and a result stream carrying one sum nibble per beat.
//
//   Signals
//     in_valid  : operand nibble pair valid              (source -> adder)
//     in_ready  : adder can accept a nibble pair         (adder  -> source)
//     in_a      : operand A nibble [3:0]                 (source -> adder)
//     in_b      : operand B nibble [3:0]                 (source -> adder)
//     in_cin    : operation carry-in, first nibble only  (source -> adder)
//     out_valid : sum nibble valid                       (adder  -> consumer)
//     out_ready : consumer accepts sum nibble            (consumer -> adder)
//     out_sum   : sum nibble [3:0]                       (adder  -> consumer)
//     out_last  : final (MSB) nibble of an operation     (adder  -> consumer)
//     out_cout  : final carry-out, valid with out_last   (adder  -> consumer)
//     out_ovf   : signed overflow, valid with out_last   (only with SIGNED_OVF_EN)
//
//   Modports
//     master : operand source / result consumer side
//     slave  : the adder itself
//
//   Optional feature macro: SIGNED_OVF_EN (adds out_ovf)
// ---------------------------------------------------------------------------
interface nibble_serial_adder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_last;
  logic       out_cout;
`ifdef SIGNED_OVF_EN
  logic       out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_last,
`ifdef SIGNED_OVF_EN
    input  out_ovf,
`endif
    input  out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_last,
`ifdef SIGNED_OVF_EN
    output out_ovf,
`endif
    output out_cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Adds two (4*NIBBLES)-bit operands one nibble per beat, LSB nibble first.
//   Each beat goes through a 4-bit ripple-carry adder; the beat's carry-out is
//   registered and becomes the next beat's carry-in. Results leave through a
//   one-deep registered valid/ready stage.
//
//   Parameters
//     NIBBLES : nibbles per operation, 2..256
//
//   Ports
//     i_clk : clock, rising edge
//     i_rst : asynchronous active-high reset
//     i_clr : synchronous abort of the in-flight operation
//     bus   : nibble_serial_adder_if.slave (operand and result streams)
//
//   Optional feature macro: SIGNED_OVF_EN
//     Adds bus.out_ovf, the two's-complement overflow of the full-width add,
//     reported on the last nibble only.
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder, one full adder per bit.
module ripple_carry_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign o_sum[0] = w_p[0] ^ i_cin;
  assign w_c1     = w_g[0] | (w_p[0] & i_cin);
  assign o_sum[1] = w_p[1] ^ w_c1;
  assign w_c2     = w_g[1] | (w_p[1] & w_c1);
  assign o_sum[2] = w_p[2] ^ w_c2;
  assign w_c3     = w_g[2] | (w_p[2] & w_c2);
  assign o_sum[3] = w_p[3] ^ w_c3;
  assign o_cout   = w_g[3] | (w_p[3] & w_c3);
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  nibble_serial_adder_if.slave   bus
);
  localparam int                 CNT_W    = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NIBBLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_cy;
  logic             r_out_valid;
  logic [3:0]       r_out_sum;
  logic             r_out_last;
  logic             r_out_cout;
`ifdef SIGNED_OVF_EN
  logic             r_out_ovf;
  logic             w_ovf;
`endif

  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_first;
  logic             w_last;
  logic             w_add_cin;
  logic [3:0]       w_sum;
  logic             w_cout;

  // One-deep output register: a new beat may enter whenever the current one
  // is absent or leaving this cycle. An abort blocks intake for its cycle.
  assign w_in_ready = !i_clr && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_xfer     = r_out_valid && bus.out_ready;

  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == LAST_IDX);
  // Operation carry-in only seeds the first nibble; later beats chain.
  assign w_add_cin = w_first ? bus.in_cin : r_cy;

  ripple_carry_adder_4bit u_rca (
    .i_a    (bus.in_a),
    .i_b    (bus.in_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

`ifdef SIGNED_OVF_EN
  // Sign bits of the full-width operands live in the last nibble, so the
  // overflow test only needs that beat's operand and sum MSBs.
  assign w_ovf = w_last && (bus.in_a[3] == bus.in_b[3]) && (w_sum[3] != bus.in_a[3]);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_cy        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= 4'h0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
      r_out_ovf   <= 1'b0;
`endif
    end else if (i_clr) begin
      r_cnt       <= '0;
      r_cy        <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SIGNED_OVF_EN
      r_out_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_last  <= w_last;
      r_out_cout  <= w_last ? w_cout : 1'b0;
`ifdef SIGNED_OVF_EN
      r_out_ovf   <= w_ovf;
`endif
      // Clearing the carry on the last beat keeps operations independent.
      r_cy        <= w_last ? 1'b0 : w_cout;
      r_cnt       <= w_last ? '0 : r_cnt + CNT_W'(1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_last  = r_out_last;
  assign bus.out_cout  = r_out_cout;
`ifdef SIGNED_OVF_EN
  assign bus.out_ovf   = r_out_ovf;
`endif
endmodule
